ptr_alloc: RTL and testbench

//  Parametrised free-pointer allocator for the linked-list memory.

---
 rtl/ll_pkg.sv | 18 +
 rtl/ptr_fifo.sv | 57 +++++
 rtl/ptr_alloc.sv | 120 ++++++++++++
 tb/tb_ptr_alloc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared types for the linked-list pointer allocator.
// N sets the node count; W_PTR and the count width follow from it.
package ll_pkg;

  parameter int N = 256;
  localparam int W_PTR = $clog2(N);

  typedef logic [W_PTR-1:0] Pointer;
  typedef logic [W_PTR:0]   cnt_t;

  typedef enum logic {
    INIT,
    RUN
  } alloc_state_t;

  localparam cnt_t CNT_FULL = cnt_t'(N);

endpackage

// File: rtl/ptr_fifo.sv
// Circular N x W_PTR pointer store with an occupancy count.
// The head entry is read combinationally so it can be offered without delay.
module ptr_fifo
  import ll_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  Pointer push_ptr,
  input  logic   pop,
  output Pointer head,
  output cnt_t   count
);

  Pointer mem_q [N];

  Pointer rd_idx_q;
  Pointer rd_idx_d;
  Pointer wr_idx_q;
  Pointer wr_idx_d;
  cnt_t   count_q;
  cnt_t   count_d;

  // Indices are W_PTR wide, so the wrap at N is free.
  always_comb begin
    rd_idx_d = rd_idx_q + Pointer'(pop);
    wr_idx_d = wr_idx_q + Pointer'(push);
    count_d  = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + cnt_t'(1);
      pop && !push: count_d = count_q - cnt_t'(1);
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      count_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx_q] <= push_ptr;
    end
  end

  assign head  = mem_q[rd_idx_q];
  assign count = count_q;

endmodule

// File: rtl/ptr_alloc.sv
// Free-pointer allocator: fills the free list after reset, then serves it FIFO.
// Define PTR_ALLOC_DBL_FREE_CHK_EN to add the double-free bitmap and err_dbl_free.
module ptr_alloc
  import ll_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output logic   alloc_vld,
  input  logic   alloc_rdy,
  output Pointer alloc_ptr,
  input  logic   free_vld,
  input  Pointer free_ptr,
  output logic   init_done,
  output cnt_t   free_cnt,
  output logic   empty
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
  ,
  output logic   err_dbl_free
`endif
);

  alloc_state_t state_q;
  alloc_state_t state_d;
  Pointer       init_idx_q;
  Pointer       init_idx_d;

  logic   run;
  logic   full;
  logic   free_ok;
  logic   chk_ok;
  logic   push;
  logic   pop;
  Pointer push_ptr;
  Pointer head;
  cnt_t   count;

  ptr_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ptr (push_ptr),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + Pointer'(1);
        if (init_idx_q == Pointer'(N - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    run       = (state_q == RUN);
    init_done = run;
    free_cnt  = count;
    empty     = (count == '0);
    full      = (count == CNT_FULL);
    alloc_vld = run && !empty;
    alloc_ptr = alloc_vld ? head : '0;
    pop       = alloc_vld && alloc_rdy;
    free_ok   = run && free_vld && !full && chk_ok;
    push      = run ? free_ok : 1'b1;
    push_ptr  = run ? free_ptr : init_idx_q;
  end

`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
  logic [N-1:0] bitmap_q;
  logic [N-1:0] bitmap_d;
  logic         err_q;
  logic         err_d;

  // A bit is set while its pointer is out with a consumer.
  always_comb begin
    chk_ok   = bitmap_q[free_ptr];
    bitmap_d = bitmap_q;
    if (pop) begin
      bitmap_d[alloc_ptr] = 1'b1;
    end
    if (free_ok) begin
      bitmap_d[free_ptr] = 1'b0;
    end
    err_d = run && free_vld && !free_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

  assign err_dbl_free = err_q;
`else
  assign chk_ok = 1'b1;
`endif

endmodule

// File: tb/tb_ptr_alloc.sv
// Directed bench for ptr_alloc with a queue model checked every negedge.
// Build with PTR_ALLOC_DBL_FREE_CHK_EN to cover the double-free check too.
module tb_ptr_alloc;
  import ll_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   alloc_rdy = 1'b0;
  logic   free_vld = 1'b0;
  Pointer free_ptr = '0;
  logic   alloc_vld;
  Pointer alloc_ptr;
  logic   init_done;
  logic   empty;
  logic [W_PTR:0] free_cnt;
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
  logic   err_dbl_free;
`endif

  ptr_alloc dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_vld (alloc_vld),
    .alloc_rdy (alloc_rdy),
    .alloc_ptr (alloc_ptr),
    .free_vld  (free_vld),
    .free_ptr  (free_ptr),
    .init_done (init_done),
    .free_cnt  (free_cnt),
    .empty     (empty)
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
    ,
    .err_dbl_free (err_dbl_free)
`endif
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: free list as a queue, plus a set of pointers held by consumers.
  Pointer q[$];
  bit     run_m;
  int     init_m;
  bit [N-1:0] held_m;
  bit     err_m;
  int     sz;
  bit     ok;
  Pointer h;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        run_m  = 1'b0;
        init_m = 0;
        held_m = '0;
        err_m  = 1'b0;
      end else if (!run_m) begin
        q.push_back(Pointer'(init_m));
        init_m++;
        if (init_m == N) run_m = 1'b1;
        err_m = 1'b0;
      end else begin
        sz = q.size();
        ok = free_vld && (sz != N);
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
        ok = ok && held_m[free_ptr];
`endif
        err_m = free_vld && !ok;
        if (sz != 0 && alloc_rdy) begin
          h = q.pop_front();
          held_m[h] = 1'b1;
        end
        if (ok) begin
          q.push_back(free_ptr);
          held_m[free_ptr] = 1'b0;
        end
      end
    end
  end

  logic exp_vld;

  initial begin
    forever begin
      @(negedge clk);
      exp_vld = run_m && (q.size() != 0);
      chk("m_alloc_vld", alloc_vld, exp_vld);
      chk("m_alloc_ptr", alloc_ptr, exp_vld ? q[0] : 0);
      chk("m_free_cnt", free_cnt, q.size());
      chk("m_empty", empty, q.size() == 0);
      chk("m_init_done", init_done, run_m);
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
      chk("m_err_dbl_free", err_dbl_free, err_m);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int k;
    k = 0;
    while (!init_done && k < N + 8) begin
      tick();
      k++;
      if (!init_done) chk("init_vld_low", alloc_vld, 0);
    end
    chk("init_cycles", k, N);
    chk("init_cnt", free_cnt, N);
    chk("init_ptr", alloc_ptr, 0);
    chk("init_vld", alloc_vld, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_vld", alloc_vld, 0);
    chk("rst_cnt", free_cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_done", init_done, 0);
    chk("rst_ptr", alloc_ptr, 0);
    rst = 1'b1;
    wait_init();

    alloc_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("seq_ptr", alloc_ptr, i);
      tick();
    end
    alloc_rdy = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_vld", alloc_vld, 0);

    free_vld = 1'b1;
    free_ptr = 7;
    chk("pre_free_vld", alloc_vld, 0);
    tick();
    chk("post_free_vld", alloc_vld, 1);
    free_ptr = 3;
    tick();
    free_vld = 1'b0;
    alloc_rdy = 1'b1;
    chk("reuse_7", alloc_ptr, 7);
    tick();
    chk("reuse_3", alloc_ptr, 3);
    tick();
    alloc_rdy = 1'b0;
    chk("reuse_empty", empty, 1);

    for (int i = 0; i < 10; i++) begin
      free_vld = 1'b1;
      free_ptr = Pointer'(100 + i);
      tick();
    end
    free_vld = 1'b0;
    chk("cnt10", free_cnt, 10);
    alloc_rdy = 1'b1;
    free_vld = 1'b1;
    free_ptr = 200;
    chk("pp_head", alloc_ptr, 100);
    tick();
    free_vld = 1'b0;
    chk("pp_cnt", free_cnt, 10);
    for (int i = 1; i < 10; i++) begin
      chk("pp_order", alloc_ptr, 100 + i);
      tick();
    end
    chk("pp_tail", alloc_ptr, 200);
    tick();
    alloc_rdy = 1'b0;
    chk("pp_empty", empty, 1);

    free_vld = 1'b1;
    free_ptr = 50;
    tick();
    free_ptr = 51;
    tick();
    free_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", alloc_vld, 1);
      chk("stall_ptr", alloc_ptr, 50);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", alloc_vld, 0);
    chk("arst_cnt", free_cnt, 0);
    chk("arst_empty", empty, 1);
    chk("arst_done", init_done, 0);
    chk("arst_ptr", alloc_ptr, 0);
    tick();
    rst = 1'b1;
    wait_init();

    free_vld = 1'b1;
    free_ptr = 5;
    tick();
    free_vld = 1'b0;
    chk("over_cnt", free_cnt, N);
    chk("over_ptr", alloc_ptr, 0);
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
    chk("dbl_err_hi", err_dbl_free, 1);
    tick();
    chk("dbl_err_lo", err_dbl_free, 0);
`endif
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    chk("one_out_cnt", free_cnt, N - 1);
    free_vld = 1'b1;
    free_ptr = 0;
    tick();
    free_vld = 1'b0;
    chk("ret_cnt", free_cnt, N);
    chk("ret_head", alloc_ptr, 1);
`ifdef PTR_ALLOC_DBL_FREE_CHK_EN
    chk("ret_err", err_dbl_free, 0);
`endif
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
